host_cmd_sequencer: RTL and testbench

- Byte-level command sequencer between the UART byte stream and the BRAM address/data decoder.
- Parses host frames, assembles the 14-bit address and PSIZE-bit data, and issues single-cycle valid/wen strobes to the decoder.
- Holds off while the simulation pipeline owns the BRAMs (`hold`).
- Collects decoder read responses with a timeout and serializes responses and acks back to the UART TX.

---
 rtl/host_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_host_cmd_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// host_cmd_sequencer
//
// Turns the host UART byte stream into single-cycle commands for the BRAM
// address/data decoder, and turns the results back into UART TX bytes.
//
// Frame: header {wen, reserved(0), addr[13:8]}, addr[7:0], then for writes
// NBYTES data bytes, MSB first. Writes are acknowledged with 0xA5. Reads
// return NBYTES bytes, MSB first. Errors return 0xEE. A bad header returns
// nothing. Every error increments err_count, which saturates at 255.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rx_valid/rx_data  UART RX byte in; rx_ready is high when the byte is taken
//   tx_valid/tx_data  UART TX byte out; tx_ready is high when the byte is taken
//   hold              simulation owns the BRAMs; no command is issued
//   dec_valid         one-cycle command strobe to the decoder
//   dec_wen           write enable that qualifies dec_valid
//   dec_addr          {dest[1:0], addr[11:0]}
//   dec_data          write data (PSIZE bits)
//   dec_valid_read    decoder read-data strobe
//   dec_data_out      decoder read data
//   busy              high whenever a frame is in progress (state is not HDR)
//   err_count         saturating error counter, cleared only by rst
// -----------------------------------------------------------------------------
module host_cmd_sequencer #(
    parameter int PSIZE   = 64,
    parameter int TIMEOUT = 16   // must be at least 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    input  logic             hold,
    output logic             dec_valid,
    output logic             dec_wen,
    output logic [13:0]      dec_addr,
    output logic [PSIZE-1:0] dec_data,
    input  logic             dec_valid_read,
    input  logic [PSIZE-1:0] dec_data_out,
    output logic             busy,
    output logic [7:0]       err_count
);

    localparam int NBYTES = (PSIZE + 7) / 8;
    localparam int SR_W   = NBYTES * 8;
    localparam int BC_W   = $clog2(NBYTES) + 1;
    localparam int TO_W   = $clog2(TIMEOUT);

    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);
    // The timer holds 0 in the first WAIT cycle. Giving up when it holds
    // TIMEOUT-2 (the cycle in which it would step to TIMEOUT-1) puts the
    // error byte on TX exactly TIMEOUT cycles after dec_valid.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

    localparam logic [7:0] ACK_OK  = 8'hA5;
    localparam logic [7:0] ACK_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_ISSUE,
        S_WAIT,
        S_TX_RESP,
        S_TX_ACK
    } state_t;

    state_t          state, state_next;
    logic            cmd_wen, cmd_wen_next;
    logic [13:0]     cmd_addr, cmd_addr_next;
    logic [SR_W-1:0] shift_reg, shift_next;
    logic [BC_W-1:0] byte_cnt, byte_cnt_next;
    logic [TO_W-1:0] timer, timer_next;
    logic [7:0]      ack_byte, ack_next;
    logic [7:0]      err_next;
    logic            err_inc;

    // State and assembly registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HDR;
            cmd_wen   <= 1'b0;
            cmd_addr  <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
            timer     <= '0;
            ack_byte  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            cmd_wen   <= cmd_wen_next;
            cmd_addr  <= cmd_addr_next;
            shift_reg <= shift_next;
            byte_cnt  <= byte_cnt_next;
            timer     <= timer_next;
            ack_byte  <= ack_next;
            err_count <= err_next;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_next    = state;
        cmd_wen_next  = cmd_wen;
        cmd_addr_next = cmd_addr;
        shift_next    = shift_reg;
        byte_cnt_next = byte_cnt;
        timer_next    = timer;
        ack_next      = ack_byte;
        err_inc       = 1'b0;
        rx_ready      = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = ack_byte;
        dec_valid     = 1'b0;

        case (state)
            S_HDR: begin
                // Gated by rst so that no byte appears taken while in reset.
                rx_ready = !rst;
                if (rx_valid) begin
                    if (rx_data[6]) begin
                        err_inc = 1'b1;
                    end else begin
                        cmd_wen_next        = rx_data[7];
                        cmd_addr_next[13:8] = rx_data[5:0];
                        state_next          = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cmd_addr_next[7:0] = rx_data;
                    if (cmd_wen) begin
                        byte_cnt_next = '0;
                        state_next    = S_DATA;
                    end else if (!cmd_addr[13]) begin
                        // dest 00/01 cannot be read back
                        ack_next   = ACK_ERR;
                        err_inc    = 1'b1;
                        state_next = S_TX_ACK;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end

            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    shift_next    = (shift_reg << 8) | SR_W'(rx_data);
                    byte_cnt_next = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (!hold) begin
                    dec_valid = 1'b1;
                    if (cmd_wen) begin
                        ack_next   = ACK_OK;
                        state_next = S_TX_ACK;
                    end else begin
                        timer_next = '0;
                        state_next = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // A response in the final cycle still beats the timeout.
                if (dec_valid_read) begin
                    shift_next    = SR_W'(dec_data_out);
                    byte_cnt_next = '0;
                    state_next    = S_TX_RESP;
                end else if (timer == TO_LAST) begin
                    ack_next   = ACK_ERR;
                    err_inc    = 1'b1;
                    state_next = S_TX_ACK;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            S_TX_RESP: begin
                tx_valid = 1'b1;
                tx_data  = shift_reg[SR_W-1 -: 8];
                if (tx_ready) begin
                    shift_next    = shift_reg << 8;
                    byte_cnt_next = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = S_HDR;
                    end
                end
            end

            S_TX_ACK: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = S_HDR;
                end
            end

            default: state_next = S_HDR;
        endcase

        err_next = err_count;
        if (err_inc && (err_count != 8'hFF)) begin
            err_next = err_count + 8'd1;
        end
    end

    assign dec_wen  = cmd_wen;
    assign dec_addr = cmd_addr;
    assign dec_data = shift_reg[PSIZE-1:0];
    assign busy     = (state != S_HDR);

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_host_cmd_sequencer
//
// Drives host frames into host_cmd_sequencer, plays the decoder (answering
// reads after a chosen delay) and the UART TX sink, and compares decoder
// commands, TX bytes, their timing and err_count against a frame-level model.
// -----------------------------------------------------------------------------
module tb_host_cmd_sequencer;

    localparam int PSIZE   = 64;
    localparam int TIMEOUT = 16;
    localparam int NB      = (PSIZE + 7) / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             hold;
    logic             dec_valid;
    logic             dec_wen;
    logic [13:0]      dec_addr;
    logic [PSIZE-1:0] dec_data;
    logic             dec_valid_read;
    logic [PSIZE-1:0] dec_data_out;
    logic             busy;
    logic [7:0]       err_count;

    host_cmd_sequencer #(.PSIZE(PSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .hold           (hold),
        .dec_valid      (dec_valid),
        .dec_wen        (dec_wen),
        .dec_addr       (dec_addr),
        .dec_data       (dec_data),
        .dec_valid_read (dec_valid_read),
        .dec_data_out   (dec_data_out),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        wen;
        logic [13:0] addr;
        logic [63:0] data;
    } dec_ev_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } tx_ev_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rx_cyc = 0;
    int          exp_err = 0;
    int          tx_mode = 0;     // 0: always ready, 1: random, 2: never ready
    int          resp_delay = 0;  // 0: decoder never answers
    logic [63:0] resp_data = '0;
    dec_ev_t     dec_q[$];
    tx_ev_t      tx_q[$];
    logic        tx_pend = 1'b0;
    int          tx_offer = 0;
    logic [7:0]  tx_prev = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: decoder commands and accepted TX bytes with their offer cycle.
    always @(negedge clk) begin
        if (dec_valid) dec_q.push_back('{cyc, dec_wen, dec_addr, dec_data});
        if (tx_valid) begin
            if (!tx_pend) begin
                tx_pend  = 1'b1;
                tx_offer = cyc;
            end else begin
                check_val("tx_hold", {56'd0, tx_data}, {56'd0, tx_prev});
            end
            tx_prev = tx_data;
            if (tx_ready) begin
                tx_q.push_back('{tx_offer, tx_data});
                tx_pend = 1'b0;
            end
        end else begin
            tx_pend = 1'b0;
        end
    end

    // Decoder model: answers a read strobe resp_delay cycles later.
    initial begin
        dec_valid_read = 1'b0;
        dec_data_out   = '0;
        forever begin
            @(negedge clk);
            if (dec_valid && !dec_wen && resp_delay > 0) begin
                repeat (resp_delay) @(posedge clk);
                #1;
                dec_valid_read = 1'b1;
                dec_data_out   = resp_data;
                @(posedge clk);
                #1;
                dec_valid_read = 1'b0;
                dec_data_out   = '0;
            end
        end
    end

    // UART TX sink
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        forever begin
            @(negedge clk);
            if (rx_ready) begin
                rx_cyc = cyc;
                break;
            end
            k++;
            if (k > 200) begin
                check_val("rx_accept", {63'd0, rx_ready}, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (busy) check_val("idle", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame plus the frame-level expectations for it.
    task automatic run_frame(input logic [7:0] hdr, input logic [7:0] a,
                             input logic [63:0] wdata, input logic [63:0] rdata,
                             input int delay, input int hold_cyc, input int mode);
        logic [13:0] addr14;
        logic        bad, wen, readable, resp_ok;
        int          exp_dv;
        addr14   = {hdr[5:0], a};
        bad      = hdr[6];
        wen      = hdr[7];
        readable = addr14[13];
        resp_ok  = (delay >= 1) && (delay <= TIMEOUT - 1);
        dec_q.delete();
        tx_q.delete();
        tx_mode    = mode;
        resp_delay = delay;
        resp_data  = rdata;
        hold       = (hold_cyc > 0);

        send_byte(hdr);
        if (!bad) begin
            send_byte(a);
            if (wen) for (int i = 0; i < NB; i++) send_byte(wdata[PSIZE-1-8*i -: 8]);
        end
        exp_dv = rx_cyc + 1;

        if (hold_cyc > 0) begin
            for (int i = 0; i < hold_cyc; i++) begin
                @(negedge clk);
                check_val("hold_dv", {63'd0, dec_valid}, 64'd0);
                check_val("hold_addr", {50'd0, dec_addr}, {50'd0, addr14});
                check_val("hold_data", dec_data, wdata);
                check_val("hold_rxrdy", {63'd0, rx_ready}, 64'd0);
                @(posedge clk);
                #1;
            end
            hold   = 1'b0;
            exp_dv = cyc;
        end

        wait_idle();
        tx_mode = 0;
        idle(25);

        if (bad) begin
            check_val("bad_ndec", dec_q.size(), 0);
            check_val("bad_ntx", tx_q.size(), 0);
            exp_err = sat_inc(exp_err);
        end else if (wen) begin
            check_val("wr_ndec", dec_q.size(), 1);
            if (dec_q.size() > 0) begin
                check_val("wr_wen", {63'd0, dec_q[0].wen}, 64'd1);
                check_val("wr_addr", {50'd0, dec_q[0].addr}, {50'd0, addr14});
                check_val("wr_data", dec_q[0].data, wdata);
                check_val("wr_dv_cyc", dec_q[0].cyc, exp_dv);
            end
            check_val("wr_ntx", tx_q.size(), 1);
            if (tx_q.size() > 0) begin
                check_val("wr_ack", {56'd0, tx_q[0].data}, 64'hA5);
                check_val("wr_ack_cyc", tx_q[0].cyc, exp_dv + 1);
            end
        end else if (!readable) begin
            check_val("nr_ndec", dec_q.size(), 0);
            check_val("nr_ntx", tx_q.size(), 1);
            if (tx_q.size() > 0) check_val("nr_ack", {56'd0, tx_q[0].data}, 64'hEE);
            exp_err = sat_inc(exp_err);
        end else begin
            check_val("rd_ndec", dec_q.size(), 1);
            if (dec_q.size() > 0) begin
                check_val("rd_wen", {63'd0, dec_q[0].wen}, 64'd0);
                check_val("rd_addr", {50'd0, dec_q[0].addr}, {50'd0, addr14});
                check_val("rd_dv_cyc", dec_q[0].cyc, exp_dv);
            end
            if (resp_ok) begin
                check_val("rd_ntx", tx_q.size(), NB);
                for (int i = 0; i < NB && i < tx_q.size(); i++)
                    check_val("rd_byte", {56'd0, tx_q[i].data}, {56'd0, rdata[PSIZE-1-8*i -: 8]});
                if (tx_q.size() > 0) check_val("rd_tx_cyc", tx_q[0].cyc, exp_dv + delay + 1);
            end else begin
                check_val("to_ntx", tx_q.size(), 1);
                if (tx_q.size() > 0) begin
                    check_val("to_ack", {56'd0, tx_q[0].data}, 64'hEE);
                    check_val("to_cyc", tx_q[0].cyc, exp_dv + TIMEOUT);
                end
                exp_err = sat_inc(exp_err);
            end
        end
        check_val("err_count", {56'd0, err_count}, exp_err);
        check_val("busy_end", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  hdr;
        logic [63:0] wd;
        int          kind;
        int          k;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        hold     = 1'b0;
        idle(3);

        // Reset state
        @(negedge clk);
        check_val("rst_txv", {63'd0, tx_valid}, 64'd0);
        check_val("rst_txd", {56'd0, tx_data}, 64'd0);
        check_val("rst_rxrdy", {63'd0, rx_ready}, 64'd0);
        check_val("rst_dv", {63'd0, dec_valid}, 64'd0);
        check_val("rst_wen", {63'd0, dec_wen}, 64'd0);
        check_val("rst_addr", {50'd0, dec_addr}, 64'd0);
        check_val("rst_data", dec_data, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_err", {56'd0, err_count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_rxrdy", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Directed frames
        run_frame(8'h81, 8'h23, 64'h1122334455667788, '0, 0, 0, 0);
        run_frame(8'h20, 8'h05, '0, 64'hDEADBEEFCAFEF00D, 5, 0, 0);
        run_frame(8'h30, 8'h00, '0, 64'h0123456789ABCDEF, TIMEOUT + 3, 0, 0);
        run_frame(8'h30, 8'h00, '0, '0, 0, 0, 0);
        run_frame(8'h31, 8'h9A, '0, 64'hA1B2C3D4E5F60718, TIMEOUT - 1, 0, 0);
        run_frame(8'h22, 8'h44, '0, 64'h5555AAAA3333CCCC, TIMEOUT, 0, 0);
        run_frame(8'h21, 8'h10, '0, 64'h0F1E2D3C4B5A6978, 1, 0, 1);
        run_frame(8'h10, 8'h00, '0, '0, 0, 0, 0);
        run_frame(8'h40, 8'h00, '0, '0, 0, 0, 0);
        run_frame(8'h81, 8'h77, 64'hCAFEBABE12345678, '0, 0, 20, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 4);
            wd   = {$urandom, $urandom};
            case (kind)
                0: begin
                    hdr = {1'($urandom), 1'b1, 6'($urandom)};
                    run_frame(hdr, 8'($urandom), '0, '0, 0, 0, $urandom_range(0, 1));
                end
                1: begin
                    hdr = {1'b1, 1'b0, 6'($urandom)};
                    run_frame(hdr, 8'($urandom), wd, '0, 0, $urandom_range(0, 4), $urandom_range(0, 1));
                end
                2: begin
                    hdr = {3'b000, 1'($urandom), 4'($urandom)};
                    run_frame(hdr, 8'($urandom), '0, '0, 0, 0, $urandom_range(0, 1));
                end
                default: begin
                    hdr = {3'b001, 1'($urandom), 4'($urandom)};
                    run_frame(hdr, 8'($urandom), '0, wd, $urandom_range(0, TIMEOUT + 3), 0,
                              $urandom_range(0, 1));
                end
            endcase
        end

        // Saturation of err_count through dropped headers
        tx_q.delete();
        for (int i = 0; i < 260; i++) begin
            send_byte({1'($urandom), 1'b1, 6'($urandom)});
            exp_err = sat_inc(exp_err);
        end
        idle(3);
        check_val("sat_err", {56'd0, err_count}, exp_err);
        check_val("sat_ntx", tx_q.size(), 0);

        // Reset in the middle of a write frame
        dec_q.delete();
        tx_q.delete();
        send_byte(8'h81);
        send_byte(8'h40);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check_val("rstmid_txv", {63'd0, tx_valid}, 64'd0);
        check_val("rstmid_dv", {63'd0, dec_valid}, 64'd0);
        check_val("rstmid_busy", {63'd0, busy}, 64'd0);
        check_val("rstmid_err", {56'd0, err_count}, 64'd0);
        idle(20);
        check_val("rstmid_ndec", dec_q.size(), 0);
        check_val("rstmid_ntx", tx_q.size(), 0);
        run_frame(8'h83, 8'h21, 64'h0102030405060708, '0, 0, 0, 0);

        // Reset while the ack byte is stalled on TX
        tx_mode = 2;
        send_byte(8'h82);
        send_byte(8'h10);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom));
        k = 0;
        @(negedge clk);
        while (!tx_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("stall_txv", {63'd0, tx_valid}, 64'd1);
        idle(4);
        tx_q.delete();
        dec_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_mode = 0;
        @(negedge clk);
        check_val("rsttx_txv", {63'd0, tx_valid}, 64'd0);
        check_val("rsttx_busy", {63'd0, busy}, 64'd0);
        idle(10);
        check_val("rsttx_ntx", tx_q.size(), 0);
        check_val("rsttx_ndec", dec_q.size(), 0);
        run_frame(8'h2F, 8'hFF, '0, 64'h8877665544332211, 3, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
